// File: rtl/pri_codec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pri_codec_pkg : constants and group helpers shared by the codec pair  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pri_codec_pkg;

    localparam int WIDTH   = 55;
    localparam int IDX_W   = 6;
    localparam int GRP_W   = 3;
    localparam int GRP_SZ  = 1 << GRP_W;
    localparam int NUM_GRP = (WIDTH + GRP_SZ - 1) / GRP_SZ;
    localparam int GIDX_W  = IDX_W - GRP_W;

    typedef logic [NUM_GRP-1:0] grp_vec_t;

    function automatic grp_vec_t onehot_grp(input logic [GIDX_W-1:0] g);
        grp_vec_t r;
        r = '0;
        for (int i = 0; i < NUM_GRP; i++) begin
            r[i] = (int'(g) == i);
        end
        return r;
    endfunction

    // Groups strictly below g are entirely covered by a thermometer ending in g.
    function automatic grp_vec_t therm_grp(input logic [GIDX_W-1:0] g);
        grp_vec_t r;
        r = '0;
        for (int i = 0; i < NUM_GRP; i++) begin
            r[i] = (i < int'(g));
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pri_grp_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pri_grp_expand : second-level decode of group selects into a vector  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pri_grp_expand
    import pri_codec_pkg::*;
(
    input  logic [NUM_GRP-1:0] grp_sel,
    input  logic [NUM_GRP-1:0] grp_below,
    input  logic [GRP_W-1:0]   l,
    input  logic               therm,
    output logic [WIDTH-1:0]   vec
);

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        for (genvar b = 0; b < GRP_SZ; b++) begin : g_bit
            // The top group is partial; bits at or above WIDTH do not exist.
            if (g * GRP_SZ + b < WIDTH) begin : g_live
                localparam logic [GRP_W-1:0] C_LJ = GRP_W'(b);
                assign vec[g*GRP_SZ+b] = therm
                    ? (grp_below[g] | (grp_sel[g] & (C_LJ <= l)))
                    : (grp_sel[g] & (C_LJ == l));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pri_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pri_decoder : 2-stage streaming index-to-onehot/thermometer decoder  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pri_decoder
    import pri_codec_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_therm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic             out_oor,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [IDX_W-1:0] C_WIDTH_IDX = IDX_W'(WIDTH);

    logic               w_adv1;
    logic               w_adv2;
    logic [GIDX_W-1:0]  w_g;
    logic               w_oor;
    logic [WIDTH-1:0]   w_vec;

    logic               r_s1_valid;
    logic [GRP_W-1:0]   r_s1_l;
    logic               r_s1_therm;
    logic               r_s1_oor;
    logic [NUM_GRP-1:0] r_s1_grp_sel;
    logic [NUM_GRP-1:0] r_s1_grp_below;

    logic               r_s2_valid;
    logic [WIDTH-1:0]   r_s2_vec;
    logic               r_s2_oor;
    logic [CNT_W-1:0]   r_count;

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    assign w_g   = in_idx[IDX_W-1:GRP_W];
    assign w_oor = (in_idx >= C_WIDTH_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_l         <= '0;
            r_s1_therm     <= 1'b0;
            r_s1_oor       <= 1'b0;
            r_s1_grp_sel   <= '0;
            r_s1_grp_below <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_l         <= in_idx[GRP_W-1:0];
                r_s1_therm     <= in_therm;
                r_s1_oor       <= w_oor;
                // Clearing both group vectors makes stage 2 emit all-zero for free.
                r_s1_grp_sel   <= w_oor ? '0 : onehot_grp(w_g);
                r_s1_grp_below <= w_oor ? '0 : therm_grp(w_g);
            end
        end
    end

    pri_grp_expand u_expand (
        .grp_sel   (r_s1_grp_sel),
        .grp_below (r_s1_grp_below),
        .l         (r_s1_l),
        .therm     (r_s1_therm),
        .vec       (w_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_vec   <= '0;
            r_s2_oor   <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_vec <= w_vec;
                r_s2_oor <= r_s1_oor;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_s2_valid && out_ready && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_vec   = r_s2_vec;
    assign out_oor   = r_s2_oor;
    assign out_count = r_count;

endmodule
`default_nettype wire
